// File: rtl/dec3to8_if.sv
// Select/decode bundle for dec3to8: the index and enable in, plus both registered
// decoder results and the cross-check flags out.
interface dec3to8_if;
   logic       en;
   logic [2:0] in;
   logic [7:0] out_shift;
   logic [7:0] out_case;
   logic [7:0] out;
   logic       mismatch;
   logic       err_sticky;

   modport master (
      output en, in,
      input  out_shift, out_case, out, mismatch, err_sticky
   );

   modport slave (
      input  en, in,
      output out_shift, out_case, out, mismatch, err_sticky
   );
endinterface

// File: rtl/dec3to8.sv
// Registered 3-to-8 decoder with two independent decode paths (shift and case)
// that are compared every cycle; any disagreement raises mismatch and err_sticky.
module dec3to8_shift (
   input  logic       en,
   input  logic [2:0] in,
   output logic [7:0] out
);
   assign out = en ? (8'b0000_0001 << in) : 8'b0000_0000;
endmodule

module dec3to8_case (
   input  logic       en,
   input  logic [2:0] in,
   output logic [7:0] out
);
   always_comb begin
      out = 8'b0000_0000;
      if (en) begin
         // An X/Z index falls through to default, deliberately disagreeing with the shift path.
         case (in)
            3'd0:    out = 8'b0000_0001;
            3'd1:    out = 8'b0000_0010;
            3'd2:    out = 8'b0000_0100;
            3'd3:    out = 8'b0000_1000;
            3'd4:    out = 8'b0001_0000;
            3'd5:    out = 8'b0010_0000;
            3'd6:    out = 8'b0100_0000;
            3'd7:    out = 8'b1000_0000;
            default: out = 8'b0000_0000;
         endcase
      end
   end
endmodule

module dec3to8 (
   input  logic        clk,
   input  logic        rst,
   dec3to8_if.slave    bus
);
   logic [7:0] shift_res;
   logic [7:0] case_res;
   logic       mismatch_next;
   logic       err_sticky_next;

   logic [7:0] out_shift_reg;
   logic [7:0] out_case_reg;
   logic [7:0] out_reg;
   logic       mismatch_reg;
   logic       err_sticky_reg;

   dec3to8_shift u_shift (
      .en  (bus.en),
      .in  (bus.in),
      .out (shift_res)
   );

   dec3to8_case u_case (
      .en  (bus.en),
      .in  (bus.in),
      .out (case_res)
   );

   assign mismatch_next   = (shift_res != case_res);
   assign err_sticky_next = err_sticky_reg | mismatch_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_shift_reg  <= 8'b0;
         out_case_reg   <= 8'b0;
         out_reg        <= 8'b0;
         mismatch_reg   <= 1'b0;
         err_sticky_reg <= 1'b0;
      end else begin
         out_shift_reg  <= shift_res;
         out_case_reg   <= case_res;
         out_reg        <= case_res;
         mismatch_reg   <= mismatch_next;
         err_sticky_reg <= err_sticky_next;
      end
   end

   assign bus.out_shift  = out_shift_reg;
   assign bus.out_case   = out_case_reg;
   assign bus.out        = out_reg;
   assign bus.mismatch   = mismatch_reg;
   assign bus.err_sticky = err_sticky_reg;
endmodule

// File: tb/tb_dec3to8.sv
// Self-checking bench for dec3to8: directed sweeps, reset cases, fault injection
// and a random run, all against a bit-by-bit reference decode.
module tb_dec3to8;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic exp_sticky = 1'b0;

   dec3to8_if bus ();

   dec3to8 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: bit k is set exactly when enabled and the index names k.
   function automatic logic [7:0] ref_dec(logic e, logic [2:0] idx);
      logic [7:0] r;
      r = 8'b0;
      for (int k = 0; k < 8; k++)
         if (e === 1'b1 && idx === 3'(k)) r[k] = 1'b1;
      return r;
   endfunction

   task automatic chk8(string tag, logic [7:0] obs, logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %b want %b", tag, obs, expv);
      end
   endtask

   task automatic chk1(string tag, logic obs, logic expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %b want %b", tag, obs, expv);
      end
   endtask

   task automatic chk_all(string tag, logic [7:0] es, logic [7:0] ec, logic em, logic est);
      chk8({tag, ".out_shift"}, bus.out_shift, es);
      chk8({tag, ".out_case"}, bus.out_case, ec);
      chk8({tag, ".out"}, bus.out, ec);
      chk1({tag, ".mismatch"}, bus.mismatch, em);
      chk1({tag, ".err_sticky"}, bus.err_sticky, est);
   endtask

   // Apply one input, take one edge, check the registered result.
   task automatic step(string tag, logic e, logic [2:0] idx);
      logic [7:0] expv;
      bus.en = e;
      bus.in = idx;
      expv = ref_dec(e, idx);
      @(posedge clk);
      #1;
      $display("txn %s en=%b in=%0d out=%b shift=%b mm=%b sticky=%b",
               tag, e, idx, bus.out, bus.out_shift, bus.mismatch, bus.err_sticky);
      chk_all(tag, expv, expv, 1'b0, exp_sticky);
   endtask

   initial begin
      bus.en = 1'b1;
      bus.in = 3'd5;
      #2;
      // Async reset before the first clock edge.
      rst = 1'b1;
      #1;
      chk_all("reset_async", 8'b0, 8'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_all("reset_held", 8'b0, 8'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) step("dis_sweep", 1'b0, 3'(i));
      for (int i = 0; i < 8; i++) step("en_sweep", 1'b1, 3'(i));

      step("lat_en1", 1'b1, 3'd3);
      step("lat_en0", 1'b0, 3'd3);
      step("lat_en1b", 1'b1, 3'd3);

      // Mid-stream reset: the in=6 sample never reaches the outputs.
      for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 3'(i));
      bus.en = 1'b1;
      bus.in = 3'd6;
      #2;
      rst = 1'b1;
      #1;
      chk_all("midrst_async", 8'b0, 8'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_all("midrst_held", 8'b0, 8'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step("post_rst", 1'b1, 3'd7);

      repeat (150) step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

      // Fault injection: case path forced to zero for in=2.
      step("pre_fault", 1'b1, 3'd1);
      bus.en = 1'b1;
      bus.in = 3'd2;
      #1;
      force dut.case_res = 8'b0;
      @(posedge clk);
      #1;
      release dut.case_res;
      exp_sticky = 1'b1;
      $display("txn fault en=1 in=2 out=%b shift=%b mm=%b sticky=%b",
               bus.out, bus.out_shift, bus.mismatch, bus.err_sticky);
      chk_all("fault", 8'b0000_0100, 8'b0, 1'b1, 1'b1);
      step("post_fault", 1'b1, 3'd3);
      step("post_fault2", 1'b0, 3'd4);

      // Only reset clears the sticky error.
      #2;
      rst = 1'b1;
      exp_sticky = 1'b0;
      #1;
      chk_all("sticky_clear", 8'b0, 8'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step("final", 1'b1, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
